// File: rtl/uart_rx_ext_if.sv
// Receive-FIFO head handshake between uart_rx_ext (master) and its consumer (slave).
// Carries the head-entry data/status flags and the consumer's accept strobe.
interface uart_rx_ext_if;
    logic       iREADY;
    logic       oVALID;
    logic [7:0] oDATA;
    logic       oPARITY_ERR;
    logic       oFRAME_ERR;
    logic       oBREAK;

    modport master (
        input  iREADY,
        output oVALID, oDATA, oPARITY_ERR, oFRAME_ERR, oBREAK
    );

    modport slave (
        output iREADY,
        input  oVALID, oDATA, oPARITY_ERR, oFRAME_ERR, oBREAK
    );
endinterface

// File: rtl/uart_rx_ext.sv
// Oversampling UART receiver with runtime frame format and a first-word-fall-through receive FIFO.
// Optional macro UART_RX_MAJORITY_EN: 3-sample majority vote around each bit centre.
module uart_rx_ext #(
    parameter int OVER_SAMPLING = 16,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          iCLK_CE,
    input  logic [1:0]                    iDATA_BITS,
    input  logic                          iPARITY_EN,
    input  logic                          iODD_PARITY,
    input  logic                          iSTOP_BIT,
    input  logic                          iUART_RX,
    input  logic                          iCLR_OVR,
    output logic                          oOVERRUN,
    output logic [$clog2(FIFO_DEPTH):0]   oLEVEL,
    output logic                          oRX_BUSY,
    uart_rx_ext_if.master                 rx_if
);

    localparam int MID   = OVER_SAMPLING / 2;
    localparam int CNT_W = $clog2(OVER_SAMPLING + 2);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
`ifdef UART_RX_MAJORITY_EN
    // Decision lands one tick after the nominal centre; counter then sits at offset +1.
    localparam int START_DEC = MID + 1;
    localparam int BIT_DEC   = OVER_SAMPLING + 1;
    localparam int RELOAD    = 1;
`else
    localparam int START_DEC = MID;
    localparam int BIT_DEC   = OVER_SAMPLING;
    localparam int RELOAD    = 0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } state_t;

    function automatic logic parity_err_f(input logic acc, input logic pbit, input logic odd);
        return acc ^ pbit ^ odd;
    endfunction

    function automatic logic majority3_f(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic             sync1_r, sync2_r;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic             stop_idx_r;
    logic [7:0]       data_r;
    logic             par_acc_r, par_err_r, frame_r, any_one_r, busy_r;
    logic [1:0]       cfg_bits_r;
    logic             cfg_par_en_r, cfg_odd_r, cfg_stop_r;

    logic             line_s, bit_s, at_dec_s, last_data_s, push_s, brk_s;
    logic [CNT_W-1:0] cur_s, dec_pt_s;
    logic [10:0]      entry_s;

    // Two-flop synchronizer on the raw serial line, clocked every cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= iUART_RX;
            sync2_r <= sync1_r;
        end
    end

    assign line_s = sync2_r;

`ifdef UART_RX_MAJORITY_EN
    logic smp_a_r, smp_b_r;

    // Capture the two early samples that precede each decision tick.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            smp_a_r <= 1'b1;
            smp_b_r <= 1'b1;
        end else if (iCLK_CE && (state_r != ST_IDLE) && (state_r != ST_WAIT_HIGH)) begin
            if (cur_s == (dec_pt_s - CNT_W'(2))) begin
                smp_a_r <= line_s;
            end
            if (cur_s == (dec_pt_s - CNT_W'(1))) begin
                smp_b_r <= line_s;
            end
        end
    end
`endif

    // Tick-position decode, bit value and the entry assembled at the last stop sample.
    always_comb begin
        cur_s       = cnt_r + CNT_W'(1);
        dec_pt_s    = (state_r == ST_START) ? CNT_W'(START_DEC) : CNT_W'(BIT_DEC);
        at_dec_s    = iCLK_CE && (cur_s == dec_pt_s);
`ifdef UART_RX_MAJORITY_EN
        bit_s       = majority3_f(smp_a_r, smp_b_r, line_s);
`else
        bit_s       = line_s;
`endif
        last_data_s = (bit_idx_r == ({1'b0, cfg_bits_r} + 3'd4));
        push_s      = at_dec_s && (state_r == ST_STOP) && (stop_idx_r == cfg_stop_r);
        brk_s       = ~any_one_r & ~bit_s;
        entry_s     = {brk_s, frame_r | ~bit_s, cfg_par_en_r & par_err_r,
                       brk_s ? 8'h00 : data_r};
    end

    // Receive state machine; everything advances only on oversampling ticks.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            bit_idx_r    <= 3'd0;
            stop_idx_r   <= 1'b0;
            data_r       <= 8'h00;
            par_acc_r    <= 1'b0;
            par_err_r    <= 1'b0;
            frame_r      <= 1'b0;
            any_one_r    <= 1'b0;
            busy_r       <= 1'b0;
            cfg_bits_r   <= 2'd3;
            cfg_par_en_r <= 1'b0;
            cfg_odd_r    <= 1'b0;
            cfg_stop_r   <= 1'b0;
        end else if (iCLK_CE) begin
            case (state_r)
                ST_IDLE: begin
                    if (!line_s) begin
                        state_r <= ST_START;
                        cnt_r   <= {CNT_W{1'b0}};
                        busy_r  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (at_dec_s) begin
                        cnt_r <= CNT_W'(RELOAD);
                        if (bit_s) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r      <= ST_DATA;
                            bit_idx_r    <= 3'd0;
                            stop_idx_r   <= 1'b0;
                            data_r       <= 8'h00;
                            par_acc_r    <= 1'b0;
                            par_err_r    <= 1'b0;
                            frame_r      <= 1'b0;
                            any_one_r    <= 1'b0;
                            cfg_bits_r   <= iDATA_BITS;
                            cfg_par_en_r <= iPARITY_EN;
                            cfg_odd_r    <= iODD_PARITY;
                            cfg_stop_r   <= iSTOP_BIT;
                        end
                    end else begin
                        cnt_r <= cur_s;
                    end
                end
                ST_DATA: begin
                    if (at_dec_s) begin
                        cnt_r             <= CNT_W'(RELOAD);
                        data_r[bit_idx_r] <= bit_s;
                        par_acc_r         <= par_acc_r ^ bit_s;
                        any_one_r         <= any_one_r | bit_s;
                        if (last_data_s) begin
                            state_r <= cfg_par_en_r ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cur_s;
                    end
                end
                ST_PARITY: begin
                    if (at_dec_s) begin
                        cnt_r     <= CNT_W'(RELOAD);
                        par_err_r <= parity_err_f(par_acc_r, bit_s, cfg_odd_r);
                        any_one_r <= any_one_r | bit_s;
                        state_r   <= ST_STOP;
                    end else begin
                        cnt_r <= cur_s;
                    end
                end
                ST_STOP: begin
                    if (at_dec_s) begin
                        cnt_r <= CNT_W'(RELOAD);
                        if (push_s) begin
                            state_r <= bit_s ? ST_IDLE : ST_WAIT_HIGH;
                            busy_r  <= ~bit_s;
                        end else begin
                            frame_r    <= frame_r | ~bit_s;
                            any_one_r  <= any_one_r | bit_s;
                            stop_idx_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cur_s;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (line_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign oRX_BUSY = busy_r;

    logic [10:0]      mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_r, wr_r, rd_nx_s;
    logic [LVL_W-1:0] count_r, count_nx_s, remain_s;
    logic [10:0]      head_r, head_nx_s;
    logic             valid_r, ovr_r;
    logic             full_s, pop_s, push_ok_s, ovr_set_s;

    // FIFO next-state: accept/reject push, pop, and the entry that becomes head.
    always_comb begin
        full_s     = (count_r == LVL_W'(FIFO_DEPTH));
        pop_s      = (count_r != {LVL_W{1'b0}}) && rx_if.iREADY;
        push_ok_s  = push_s && (!full_s || pop_s);
        ovr_set_s  = push_s && full_s && !pop_s;
        count_nx_s = count_r + {{(LVL_W-1){1'b0}}, push_ok_s} - {{(LVL_W-1){1'b0}}, pop_s};
        remain_s   = count_r - {{(LVL_W-1){1'b0}}, pop_s};
        rd_nx_s    = rd_r + {{(PTR_W-1){1'b0}}, pop_s};
        if (remain_s != {LVL_W{1'b0}}) begin
            head_nx_s = mem_r[rd_nx_s];
        end else if (push_ok_s) begin
            head_nx_s = entry_s;
        end else begin
            head_nx_s = 11'h000;
        end
    end

    // Storage array; contents are qualified by the pointers, so no reset is needed.
    always_ff @(posedge CLK) begin
        if (push_ok_s) begin
            mem_r[wr_r] <= entry_s;
        end
    end

    // FIFO pointers, occupancy, registered head outputs and sticky overrun.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_r    <= {PTR_W{1'b0}};
            wr_r    <= {PTR_W{1'b0}};
            count_r <= {LVL_W{1'b0}};
            head_r  <= 11'h000;
            valid_r <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            rd_r    <= rd_nx_s;
            wr_r    <= wr_r + {{(PTR_W-1){1'b0}}, push_ok_s};
            count_r <= count_nx_s;
            head_r  <= head_nx_s;
            valid_r <= (count_nx_s != {LVL_W{1'b0}});
            if (ovr_set_s) begin
                ovr_r <= 1'b1;
            end else if (iCLR_OVR) begin
                ovr_r <= 1'b0;
            end
        end
    end

    assign rx_if.oVALID      = valid_r;
    assign rx_if.oDATA       = head_r[7:0];
    assign rx_if.oPARITY_ERR = head_r[8];
    assign rx_if.oFRAME_ERR  = head_r[9];
    assign rx_if.oBREAK      = head_r[10];
    assign oLEVEL            = count_r;
    assign oOVERRUN          = ovr_r;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: frame formats, errors, break, glitch, FIFO overrun and reset.
module tb_uart_rx_ext;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       ce = 1'b1;
    logic [1:0] data_bits = 2'd3;
    logic       par_en = 1'b0;
    logic       odd = 1'b0;
    logic       stop2 = 1'b0;
    logic       rx = 1'b1;
    logic       clr_ovr = 1'b0;
    logic       overrun;
    logic [3:0] level;
    logic       busy;

    int          n_chk = 0;
    int          n_fail = 0;
    int          vcnt = 0;
    logic [10:0] q[$];
    logic [10:0] e;

    uart_rx_ext_if ifc ();

    uart_rx_ext #(.OVER_SAMPLING(16), .FIFO_DEPTH(8)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .iCLK_CE     (ce),
        .iDATA_BITS  (data_bits),
        .iPARITY_EN  (par_en),
        .iODD_PARITY (odd),
        .iSTOP_BIT   (stop2),
        .iUART_RX    (rx),
        .iCLR_OVR    (clr_ovr),
        .oOVERRUN    (overrun),
        .oLEVEL      (level),
        .oRX_BUSY    (busy),
        .rx_if       (ifc)
    );

    always #5 CLK = ~CLK;

    // Record every entry the consumer takes, sampled mid-cycle.
    always @(negedge CLK) begin
        if (RST_N && ifc.oVALID) begin
            vcnt = vcnt + 1;
            if (ifc.iREADY) begin
                q.push_back({ifc.oBREAK, ifc.oFRAME_ERR, ifc.oPARITY_ERR, ifc.oDATA});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic take(output logic [10:0] ent);
        if (q.size() > 0) begin
            ent = q.pop_front();
        end else begin
            ent = 11'h7FF;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input logic pe,
                              input logic pv, input int ns, input logic sv);
        rx = 1'b0;
        cyc(16);
        for (int i = 0; i < nb; i++) begin
            rx = d[i];
            cyc(16);
        end
        if (pe) begin
            rx = pv;
            cyc(16);
        end
        for (int i = 0; i < ns; i++) begin
            rx = sv;
            cyc(16);
        end
        rx = 1'b1;
        cyc(8);
    endtask

    initial begin
        ifc.iREADY = 1'b1;
        cyc(3);
        chk("rst_valid", ifc.oVALID, 1'b0);
        chk("rst_data", ifc.oDATA, 8'h00);
        chk("rst_flags", {ifc.oBREAK, ifc.oFRAME_ERR, ifc.oPARITY_ERR}, 3'b000);
        chk("rst_level", level, 4'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
        RST_N = 1'b1;
        cyc(4);

        // 8N1 0xA5
        vcnt = 0;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
        chk("a5_count", q.size(), 1);
        take(e);
        chk("a5_entry", e, 11'h0A5);
        chk("a5_valid_cycles", vcnt, 1);
        chk("a5_busy_after", busy, 1'b0);

        // 7 data, odd parity, 2 stop, wrong parity bit
        data_bits = 2'd2; par_en = 1'b1; odd = 1'b1; stop2 = 1'b1;
        send_frame(8'h55, 7, 1'b1, 1'b0, 2, 1'b1);
        take(e);
        chk("7o2_bad_parity", e, 11'h155);

        // 6 data, even parity, correct parity bit
        data_bits = 2'd1; odd = 1'b0; stop2 = 1'b0;
        send_frame(8'h2A, 6, 1'b1, 1'b1, 1, 1'b1);
        take(e);
        chk("6e1_good_parity", e, 11'h02A);

        // 5 data, no parity: upper bits zero
        data_bits = 2'd0; par_en = 1'b0;
        send_frame(8'hFF, 5, 1'b0, 1'b0, 1, 1'b1);
        take(e);
        chk("5n1_data", e, 11'h01F);

        // 8N1 with stop bit low -> frame error
        data_bits = 2'd3;
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b0);
        take(e);
        chk("frame_err", e, 11'h23C);
        cyc(4);
        chk("frame_err_idle", busy, 1'b0);

        // Break: line low for 12 bit times
        q.delete();
        rx = 1'b0;
        cyc(192);
        chk("break_count", q.size(), 1);
        take(e);
        chk("break_entry", e, 11'h600);
        chk("break_wait_busy", busy, 1'b1);
        rx = 1'b1;
        cyc(32);
        chk("break_no_more", q.size(), 0);
        chk("break_idle", busy, 1'b0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1);
        take(e);
        chk("after_break", e, 11'h05A);

        // Short low pulse of mid-1 ticks is rejected
        rx = 1'b0;
        cyc(5);
        chk("glitch_start_busy", busy, 1'b1);
        cyc(2);
        rx = 1'b1;
        cyc(20);
        chk("glitch_idle", busy, 1'b0);
        chk("glitch_no_entry", q.size(), 0);

        // Overrun: 9 bytes with consumer stalled
        ifc.iREADY = 1'b0;
        for (int b = 1; b <= 9; b++) begin
            send_frame(8'(b), 8, 1'b0, 1'b0, 1, 1'b1);
        end
        chk("ovr_level", level, 4'd8);
        chk("ovr_flag", overrun, 1'b1);
        chk("ovr_valid", ifc.oVALID, 1'b1);
        ce = 1'b0;
        for (int b = 1; b <= 8; b++) begin
            chk($sformatf("drain_%0d", b), ifc.oDATA, 8'(b));
            ifc.iREADY = 1'b1;
            cyc(1);
            ifc.iREADY = 1'b0;
            if (b == 1) chk("drain_level7", level, 4'd7);
        end
        chk("drain_empty", ifc.oVALID, 1'b0);
        chk("drain_level0", level, 4'd0);
        chk("drain_data0", ifc.oDATA, 8'h00);
        chk("ovr_sticky", overrun, 1'b1);
        clr_ovr = 1'b1;
        cyc(1);
        clr_ovr = 1'b0;
        chk("ovr_cleared", overrun, 1'b0);
        ce = 1'b1;
        ifc.iREADY = 1'b1;
        q.delete();

        // Reset in the middle of a frame
        rx = 1'b0;
        cyc(16);
        rx = 1'b1;
        cyc(48);
        RST_N = 1'b0;
        cyc(2);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_level", level, 4'd0);
        RST_N = 1'b1;
        cyc(20);
        chk("midrst_no_entry", q.size(), 0);
        send_frame(8'h33, 8, 1'b0, 1'b0, 1, 1'b1);
        chk("midrst_count", q.size(), 1);
        take(e);
        chk("midrst_entry", e, 11'h033);

        // 0x00 with a one-tick high glitch at the centre of bit 3
        rx = 1'b0;
        cyc(64);
        cyc(8);
        rx = 1'b1;
        cyc(1);
        rx = 1'b0;
        cyc(7);
        cyc(64);
        rx = 1'b1;
        cyc(24);
        take(e);
`ifdef UART_RX_MAJORITY_EN
        chk("bit3_glitch", e, 11'h000);
`else
        chk("bit3_glitch", e, 11'h008);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_ext.md
UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 SHALL: OVER_SAMPLING, 16, iCLK_CE ticks per bit; even, >=4.
REQ-002 SHALL: FIFO_DEPTH, 8, receive FIFO entries; power of 2, >=2.
REQ-003 SHALL: CLK  in  1  clock.
REQ-004 SHALL: RST_N  in  1  reset, asynchronous, active-low.
REQ-005 SHALL: iCLK_CE  in  1  oversampling tick enable; one tick = one CLK cycle with iCLK_CE=1.
REQ-006 SHALL: iDATA_BITS  in  2  data length; 0=5, 1=6, 2=7, 3=8 bits.
REQ-007 SHALL: iPARITY_EN  in  1  1 = parity bit present.
REQ-008 SHALL: iODD_PARITY  in  1  0 = even, 1 = odd.
REQ-009 SHALL: iSTOP_BIT  in  1  0 = 1 stop bit, 1 = 2 stop bits.
REQ-010 SHALL: iUART_RX  in  1  asynchronous serial line, idle high.
REQ-011 SHALL: iREADY  in  1  consumer accepts head entry.
REQ-012 SHALL: iCLR_OVR  in  1  clears oOVERRUN.
REQ-013 SHALL: oVALID  out  1  FIFO not empty.
REQ-014 SHALL: oDATA  out  8  head data, right-justified, unused upper bits 0.
REQ-015 SHALL: oPARITY_ERR, oFRAME_ERR, oBREAK  out  1 each  head entry status flags.
REQ-016 SHALL: oOVERRUN  out  1  sticky overrun flag.
REQ-017 SHALL: oLEVEL  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-018 SHALL: oRX_BUSY  out  1  receiver not in IDLE.

Function
REQ-019 SHALL: iUART_RX pass through a 2-flop synchronizer clocked every CLK (not CE-gated); all sampling uses its output.
REQ-020 SHALL: states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH; all transitions and counters advance only on ticks.
REQ-021 SHALL: IDLE -> START on the first tick with line low (tick 0); mid = OVER_SAMPLING/2.
REQ-022 SHALL: at tick mid, line high -> IDLE (glitch, nothing pushed); line low -> DATA.
REQ-023 SHALL: data bit n (LSB first) sampled at tick mid+(n+1)*OVER_SAMPLING; after last bit -> PARITY if iPARITY_EN else STOP.
REQ-024 SHALL: parity sampled one bit period after last data bit; parity error = XOR(data bits, parity bit, iODD_PARITY) over configured length only.
REQ-025 SHALL: each stop bit sampled at one-bit spacing; any stop sample 0 sets frame error; second stop bit sampled only if iSTOP_BIT=1.
REQ-026 SHALL: break = all data, parity and stop samples 0; break entry carries data 0, oFRAME_ERR=1, oBREAK=1.
REQ-027 SHALL: entry {break, frame, parity, data} pushed on the tick of the last stop sample; then IDLE if line high at that sample, else WAIT_HIGH.
REQ-028 SHALL: WAIT_HIGH -> IDLE on first tick with line high; no start detection in WAIT_HIGH.
REQ-029 SHALL: FIFO first-word-fall-through; entry visible at oVALID/oDATA/flags one CLK after its push tick.
REQ-030 SHALL: pop on any CLK with oVALID=1 and iREADY=1, independent of iCLK_CE; iREADY ignored when empty.
REQ-031 SHALL: push to full FIFO without same-cycle pop discards new entry and sets oOVERRUN; FIFO contents unchanged.
REQ-032 SHALL: push and pop same cycle when full both take effect, no overrun; when empty, push only.
REQ-033 SHALL: pointers wrap modulo FIFO_DEPTH; oLEVEL ranges 0..FIFO_DEPTH.
REQ-034 SHALL: oOVERRUN cleared by iCLR_OVR; set wins over simultaneous clear.
REQ-035 SHALL: iDATA_BITS, iPARITY_EN, iSTOP_BIT, iODD_PARITY sampled at START->DATA and held for the frame.

Reset
REQ-036 SHALL: RST_N low asynchronously forces IDLE, counters 0, synchronizer flops 1, FIFO empty, oVALID 0, oDATA 0, all flags 0, oLEVEL 0, oRX_BUSY 0.
REQ-037 SHALL: reset mid-frame discards the partial frame; receiver restarts at next falling edge after release.

Configuration
REQ-038 SHALL: macro UART_RX_MAJORITY_EN defined -> each bit value = majority of samples at ticks mid-1, mid, mid+1 of its bit period (start check included, decided at mid+1, bit timing unchanged).
REQ-039 SHALL: UART_RX_MAJORITY_EN undefined -> single sample at mid; no extra sample registers.

Verification
REQ-040 SHALL: 8N1, byte 0xA5, iREADY=1 -> one entry oDATA=0xA5, all flags 0, oVALID for exactly 1 CLK.
REQ-041 SHALL: 7 data bits, odd parity, 2 stop, 0x55 with wrong parity bit -> oDATA=0x55, oPARITY_ERR=1, oFRAME_ERR=0.
REQ-042 SHALL: line low for 12 bit times at 8N1 -> one entry data 0x00, oBREAK=1, oFRAME_ERR=1; no further entry until line high then new start.
REQ-043 SHALL: low pulse of mid-1 ticks on idle line -> no entry, state returns IDLE.
REQ-044 SHALL: FIFO_DEPTH=8, iREADY=0, 9 bytes 0x01..0x09 -> oLEVEL=8, oOVERRUN=1, popped order 0x01..0x08; iCLR_OVR clears flag.
REQ-045 SHALL: with UART_RX_MAJORITY_EN, 1-tick glitch at mid of bit 3 of 0x00 -> oDATA=0x00; without macro -> oDATA=0x08.
